instr_fetch_queue: RTL and testbench

- Front of the pipelined CPU, upstream of the IF/ID pipe register. Replaces the direct PC -> Instr_Memory path.
- Owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned words, each paired with its PC+4, in a small show-ahead FIFO. The FIFO feeds IF/ID and honours an ID-stage stall.
- A branch/jump redirect flushes the queue and restarts fetch at the new PC.

---
 rtl/instr_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, keeps one request outstanding to a
// variable-latency instruction memory and buffers {pc+4, instr} pairs in a show-ahead FIFO.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_plus_four_o,
  input  logic        id_stall_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc4_mem   [DEPTH];

  state_t        w_state_next;
  logic [31:0]   w_pc_next;
  logic [31:0]   w_pc_plus4;
  logic [AW:0]   w_count_next;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_rsp      = (r_state == ST_WAIT) && imem_rvalid_i;
  assign w_push     = w_rsp && !redirect_i;
  assign w_pop      = (r_count != '0) && !id_stall_i && !redirect_i;

  // Redirect wins over every other event: queue empties and the PC jumps.
  always_comb begin
    w_count_next = r_count;
    w_pc_next    = r_pc;
    if (redirect_i) begin
      w_count_next = '0;
      w_pc_next    = redirect_pc_i;
    end else begin
      w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_rsp) begin
        w_pc_next = w_pc_plus4;
      end else begin
        w_pc_next = r_pc;
      end
    end
  end

  // Fetch FSM transition; a redirect with a request in flight parks in DROP to eat its response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (redirect_i || (r_count < FULL_CNT)) w_state_next = ST_REQ;
        else                                    w_state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (redirect_i) w_state_next = ST_DROP;
        else            w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (w_count_next < FULL_CNT) w_state_next = ST_REQ;
          else                         w_state_next = ST_IDLE;
        end else if (redirect_i) begin
          w_state_next = ST_DROP;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) w_state_next = ST_REQ;
        else               w_state_next = ST_DROP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_req    <= 1'b0;
      r_addr   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      if (redirect_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_req  <= (w_state_next == ST_REQ);
      r_addr <= (w_state_next == ST_REQ) ? w_pc_next : 32'd0;
    end
  end

  // Storage needs no reset: contents are only visible while the entry is counted.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata_i;
      r_pc4_mem[r_wr_ptr]   <= w_pc_plus4;
    end
  end

  assign imem_req_o        = r_req;
  assign imem_addr_o       = r_addr;
  assign if_valid_o        = (r_count != '0);
  assign if_instr_o        = if_valid_o ? r_instr_mem[r_rd_ptr] : 32'd0;
  assign if_pc_plus_four_o = if_valid_o ? r_pc4_mem[r_rd_ptr]   : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch queue.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] MASK     = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_plus_four_o;
  logic        id_stall_i = 1'b0;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o), .if_instr_o(if_instr_o),
    .if_pc_plus_four_o(if_pc_plus_four_o), .id_stall_i(id_stall_i)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: answers each request after lat cycles with addr ^ MASK.
  int          lat = 1;
  bit          rand_lat = 1'b0;
  bit          pend = 1'b0;
  int          rem = 0;
  logic [31:0] pend_addr = 32'd0;
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    forever begin
      @(negedge clk_i);
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'd0;
      if (pend) begin
        rem = rem - 1;
        if (rem == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = pend_addr ^ MASK;
          pend = 1'b0;
        end
      end
      if (imem_req_o) begin
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        rem       = rand_lat ? int'($urandom_range(4, 1)) : lat;
      end
    end
  end

  // Reference model: queue of expected {instr, pc+4}, outstanding request bookkeeping.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        mq[$];
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_exp = RESET_PC;
  int          m_pops = 0;
  initial begin
    forever begin
      @(posedge clk_i);
      if (!rst_i) begin
        mq.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_exp   = RESET_PC;
      end else begin
        bit          good;
        logic [31:0] raddr;
        good  = 1'b0;
        raddr = m_addr;
        if (m_out && imem_rvalid_i) begin
          m_out = 1'b0;
          good  = !m_stale && !redirect_i;
        end
        if (imem_req_o) begin
          m_out   = 1'b1;
          m_stale = 1'b0;
          m_addr  = imem_addr_o;
        end
        if (!redirect_i && mq.size() > 0 && !id_stall_i) begin
          void'(mq.pop_front());
          m_pops++;
        end
        if (good) begin
          mq.push_back('{instr: raddr ^ MASK, pc4: raddr + 32'd4});
          m_exp = raddr + 32'd4;
        end
        if (redirect_i) begin
          mq.delete();
          m_stale = 1'b1;
          m_exp   = redirect_pc_i;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    id_stall_i = 1'b0;
    pend = 1'b0;
    lat = 1;
    rand_lat = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    pend = 1'b0;
    repeat (2) tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_instr_o !== 32'd0 || if_pc_plus_four_o !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0/0", if_instr_o, if_pc_plus_four_o); end
    do_reset();
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0) begin
      errors++; $display("FAIL first_req: got %b/%h expected 1/0", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", if_valid_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'(4*(k+1)) || if_instr_o !== (32'(4*k) ^ MASK)) begin
        errors++; $display("FAIL stream_head%0d: got %b/%h/%h expected 1/%h/%h", k, if_valid_o,
                           if_pc_plus_four_o, if_instr_o, 32'(4*(k+1)), 32'(4*k) ^ MASK); end
      tick();
      checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL stream_gap%0d: got %b expected 0", k, if_valid_o); end
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    bit got = 1'b0;
    logic [31:0] first = 32'd0;
    do_reset();
    id_stall_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req_o) nreq++;
    end
    checks++; if (nreq !== 4) begin errors++; $display("FAIL stall_reqs: got %0d expected 4", nreq); end
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'd4) begin
      errors++; $display("FAIL stall_hold: got req %b valid %b pc4 %h expected 0/1/4", imem_req_o, if_valid_o, if_pc_plus_four_o); end
    id_stall_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 3) begin
        checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'(8 + 4*k)) begin
          errors++; $display("FAIL drain%0d: got %b/%h expected 1/%h", k, if_valid_o, if_pc_plus_four_o, 32'(8 + 4*k)); end
      end
      if (imem_req_o && !got) begin got = 1'b1; first = imem_addr_o; end
    end
    checks++; if (!got || first !== 32'd16) begin
      errors++; $display("FAIL resume_addr: got %b/%h expected 1/00000010", got, first); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    id_stall_i = 1'b1;
    repeat (8) tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'd4) begin
      errors++; $display("FAIL full_pre: got %b/%h expected 1/4", if_valid_o, if_pc_plus_four_o); end
    id_stall_i = 1'b0;
    tick();
    id_stall_i = 1'b1;
    checks++; if (if_pc_plus_four_o !== 32'd8 || imem_req_o !== 1'b1 || imem_addr_o !== 32'd16) begin
      errors++; $display("FAIL full_both: got pc4 %h req %b addr %h expected 8/1/10", if_pc_plus_four_o, imem_req_o, imem_addr_o); end
    repeat (4) tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_idle: got %b expected 0", imem_req_o); end
    id_stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'(8 + 4*k)) begin
        errors++; $display("FAIL full_order%0d: got %b/%h expected 1/%h", k, if_valid_o, if_pc_plus_four_o, 32'(8 + 4*k)); end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3;
    repeat (9) tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd8) begin
      errors++; $display("FAIL drop_req8: got %b/%h expected 1/8", imem_req_o, imem_addr_o); end
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL drop_empty%0d: got %b expected 0", k, if_valid_o); end
      if (k == 2) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
          errors++; $display("FAIL drop_newreq: got %b/%h expected 1/40", imem_req_o, imem_addr_o); end
      end
      tick();
    end
    checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'h44 || if_instr_o !== (32'h40 ^ MASK)) begin
      errors++; $display("FAIL drop_head: got %b/%h/%h expected 1/44/%h", if_valid_o, if_pc_plus_four_o, if_instr_o, 32'h40 ^ MASK); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    id_stall_i = 1'b1;
    repeat (6) tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'd4) begin
      errors++; $display("FAIL rr_pre: got %b/%h expected 1/4", if_valid_o, if_pc_plus_four_o); end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    id_stall_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL rr_flush: got valid %b req %b addr %h expected 0/1/100", if_valid_o, imem_req_o, imem_addr_o); end
    repeat (2) tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== 32'h104 || if_instr_o !== (32'h100 ^ MASK)) begin
      errors++; $display("FAIL rr_head: got %b/%h/%h expected 1/104/%h", if_valid_o, if_pc_plus_four_o, if_instr_o, 32'h100 ^ MASK); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    lat = 3;
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'd0 || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL rw_async: got %b/%h/%b expected 0/0/0", imem_req_o, imem_addr_o, if_valid_o); end
    repeat (3) tick();
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0 || if_instr_o !== 32'd0 || if_pc_plus_four_o !== 32'd0) begin
      errors++; $display("FAIL rw_stray: got %b/%b/%h/%h expected 0/0/0/0", if_valid_o, imem_req_o, if_instr_o, if_pc_plus_four_o); end
    rst_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL rw_restart: got %b/%h/%b expected 1/%h/0", imem_req_o, imem_addr_o, if_valid_o, RESET_PC); end
    repeat (4) tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_plus_four_o !== RESET_PC + 32'd4) begin
      errors++; $display("FAIL rw_head: got %b/%h expected 1/%h", if_valid_o, if_pc_plus_four_o, RESET_PC + 32'd4); end
  endtask

  task automatic test_random();
    logic [31:0] tmp;
    do_reset();
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++; if (if_valid_o !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, if_valid_o, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (if_instr_o !== mq[0].instr || if_pc_plus_four_o !== mq[0].pc4) begin
          errors++; $display("FAIL rnd_head@%0d: got %h/%h expected %h/%h", c, if_instr_o, if_pc_plus_four_o, mq[0].instr, mq[0].pc4); end
      end
      if (imem_req_o) begin
        checks++; if (imem_addr_o !== m_exp || m_out) begin
          errors++; $display("FAIL rnd_req@%0d: got addr %h outstanding %b expected %h/0", c, imem_addr_o, m_out, m_exp); end
      end
      checks++; if (mq.size() > DEPTH) begin
        errors++; $display("FAIL rnd_overflow@%0d: got %0d entries expected <= %0d", c, mq.size(), DEPTH); end
      id_stall_i = ($urandom_range(99, 0) < 35);
      redirect_i = ($urandom_range(99, 0) < 4);
      tmp = $urandom;
      redirect_pc_i = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : (tmp & 32'hFFFF_FFFC);
    end
    redirect_i = 1'b0;
    checks++; if (m_pops < 200) begin errors++; $display("FAIL rnd_progress: got %0d pops expected >= 200", m_pops); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_full_pushpop();
    test_redirect_drop();
    test_redirect_rvalid();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
